// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR controller AXI-side write path.
package ddr_axi_pkg;

  localparam logic [1:0]  BRESP_OKAY   = 2'b00;
  localparam logic [1:0]  BRESP_SLVERR = 2'b10;
  localparam int unsigned CFG_OFFSET_W = 8;
  localparam int unsigned BURST_LEN_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    CFG_DATA,
    CFG_STROBE,
    CFG_CHECK,
    CFG_DRAIN,
    MEM_DATA,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi_write_frontend_if.sv
// Host AW/W/B channels, config_register strobe path and memory write-request path.
interface axi_write_frontend_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  import ddr_axi_pkg::*;

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_W-1:0]       awaddr;
  logic [BURST_LEN_W-1:0]  awlen;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_W-1:0]       wdata;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    config_wstrobe;
  logic [CFG_OFFSET_W-1:0] waddr;
  logic [63:0]             cfg_wdata;
  logic [BURST_LEN_W-1:0]  wburst;
  logic                    werr;
  logic                    config_update;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic [DATA_W-1:0]       mem_req_data;
  logic                    mem_req_last;

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
           werr, config_update, mem_req_ready,
    output awready, wready, bvalid, bresp, config_wstrobe, waddr,
           cfg_wdata, wburst, mem_req_valid, mem_req_addr, mem_req_data,
           mem_req_last
  );

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
           werr, config_update, mem_req_ready,
    input  awready, wready, bvalid, bresp, config_wstrobe, waddr,
           cfg_wdata, wburst, mem_req_valid, mem_req_addr, mem_req_data,
           mem_req_last
  );

endinterface

// File: rtl/axi_write_frontend.sv
// Write-channel front end: routes host write bursts to config_register
// (single strobe per burst) or beat-by-beat to the memory write-request port.
module axi_write_frontend
  import ddr_axi_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 64,
  parameter logic [ADDR_W-9:0] CFG_BASE = '0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  axi_write_frontend_if.slave  bus
);

  localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);

  wr_state_t               state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BURST_LEN_W-1:0]  len_q, len_d;
  logic [BURST_LEN_W-1:0]  beat_q, beat_d;
  logic                    err_q, err_d;
  logic [CFG_OFFSET_W-1:0] waddr_q, waddr_d;
  logic [63:0]             cfg_wdata_q, cfg_wdata_d;
  logic [BURST_LEN_W-1:0]  wburst_q, wburst_d;

  logic                    last_beat;
  logic [ADDR_W-1:0]       beat_off;

  assign last_beat = (beat_q == len_q);
  assign beat_off  = ADDR_W'(beat_q) << BYTE_SH;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      waddr_q     <= '0;
      cfg_wdata_q <= '0;
      wburst_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      waddr_q     <= waddr_d;
      cfg_wdata_q <= cfg_wdata_d;
      wburst_q    <= wburst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    err_d       = err_q;
    waddr_d     = waddr_q;
    cfg_wdata_d = cfg_wdata_q;
    wburst_d    = wburst_q;

    bus.awready        = 1'b0;
    bus.wready         = 1'b0;
    bus.bvalid         = 1'b0;
    bus.bresp          = BRESP_OKAY;
    bus.config_wstrobe = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_data   = '0;
    bus.mem_req_last   = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.awready = 1'b1;
        if (bus.awvalid) begin
          addr_d  = bus.awaddr;
          len_d   = bus.awlen;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = (bus.awaddr[ADDR_W-1:8] == CFG_BASE) ? CFG_DATA : MEM_DATA;
        end
      end
      CFG_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          waddr_d     = addr_q[CFG_OFFSET_W-1:0];
          cfg_wdata_d = bus.wdata[63:0];
          wburst_d    = len_q;
          if (bus.wlast != last_beat) err_d = 1'b1;
          if (!last_beat) beat_d = beat_q + 1'b1;
          state_d = CFG_STROBE;
        end
      end
      CFG_STROBE: begin
        bus.config_wstrobe = 1'b1;
        state_d            = CFG_CHECK;
      end
      CFG_CHECK: begin
        if (bus.werr || !bus.config_update) err_d = 1'b1;
        state_d = (len_q == '0) ? RESP : CFG_DRAIN;
      end
      CFG_DRAIN: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          if (bus.wlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = RESP;
          else           beat_d  = beat_q + 1'b1;
        end
      end
      MEM_DATA: begin
        // Combinational pass-through: the memory side's ready is our wready.
        bus.mem_req_valid = bus.wvalid;
        bus.wready        = bus.mem_req_ready;
        bus.mem_req_data  = bus.wdata;
        bus.mem_req_addr  = addr_q + beat_off;
        bus.mem_req_last  = last_beat;
        if (bus.wvalid && bus.mem_req_ready) begin
          if (bus.wlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = RESP;
          else           beat_d  = beat_q + 1'b1;
        end
      end
      RESP: begin
        bus.bvalid = 1'b1;
        bus.bresp  = err_q ? BRESP_SLVERR : BRESP_OKAY;
        if (bus.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.waddr     = waddr_q;
  assign bus.cfg_wdata = cfg_wdata_q;
  assign bus.wburst    = wburst_q;

endmodule

// File: tb/tb_axi_write_frontend.sv
// Bench for axi_write_frontend: transaction table plus hand sequences for
// exact config latency, response back-pressure and mid-burst reset.
module tb_axi_write_frontend;
  import ddr_axi_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  bit   rdy_toggle = 1'b0;

  always #5 clk = ~clk;

  axi_write_frontend_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_write_frontend #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .CFG_BASE(24'h0)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );

  // config_register model: only offset 0 with a single-beat burst succeeds
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.werr          <= 1'b0;
      bus.config_update <= 1'b0;
    end else begin
      bus.werr          <= bus.config_wstrobe && !(bus.waddr == 8'h00 && bus.wburst == 3'd0);
      bus.config_update <= bus.config_wstrobe &&  (bus.waddr == 8'h00 && bus.wburst == 3'd0);
    end
  end

  // memory side ready: steady 1, or alternating when rdy_toggle is set
  always @(posedge clk) begin
    #1;
    bus.mem_req_ready = rdy_toggle ? ~bus.mem_req_ready : 1'b1;
  end

  int          strobes = 0, mem_n = 0, w_n = 0, bvalid_n = 0;
  logic [7:0]  s_waddr;
  logic [2:0]  s_wburst;
  logic [63:0] s_wdata;
  logic [31:0] m_addr [64];
  logic [63:0] m_data [64];
  logic        m_last [64];

  always @(negedge clk) begin
    if (bus.config_wstrobe) begin
      strobes  = strobes + 1;
      s_waddr  = bus.waddr;
      s_wburst = bus.wburst;
      s_wdata  = bus.cfg_wdata;
    end
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      m_addr[mem_n % 64] = bus.mem_req_addr;
      m_data[mem_n % 64] = bus.mem_req_data;
      m_last[mem_n % 64] = bus.mem_req_last;
      mem_n = mem_n + 1;
    end
    if (bus.wvalid && bus.wready) w_n = w_n + 1;
    if (bus.bvalid) bvalid_n = bvalid_n + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  len;
    logic [7:0]  wlast_mask;
    bit          toggle;
    logic [63:0] data;
    logic [1:0]  exp_bresp;
    int          exp_strobes;
    logic [7:0]  exp_waddr;
    logic [2:0]  exp_wburst;
    int          exp_mem;
  } vec_t;

  vec_t vecs [9];

  task automatic run_txn(input logic [31:0] a, input logic [2:0] len, input logic [7:0] mask,
                         input logic [63:0] base, output logic [1:0] resp, output bit ok);
    bit got;
    ok   = 1'b1;
    resp = 2'bxx;
    @(posedge clk); #1;
    bus.awvalid = 1'b1; bus.awaddr = a; bus.awlen = len;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); got = bus.awready;
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    if (!got) ok = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wvalid = 1'b1; bus.wdata = base + 64'(b); bus.wlast = mask[b];
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk); got = bus.wready;
      end
      @(posedge clk); #1;
      if (!got) ok = 1'b0;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); got = bus.bvalid; resp = bus.bresp;
    end
    @(posedge clk); #1;
    bus.bready = 1'b0;
    if (!got) ok = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    bit          ok;
    int          s0, m0, w0, b0;
    logic [31:0] ea;

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wlast = 1'b0; bus.bready = 1'b0;

    //            addr          len  mask   tog data                    bresp  str waddr wb  mem
    vecs[0] = '{32'h0000_0000, 3'd0, 8'h01, 0, 64'h2,                  2'b00, 1, 8'h00, 3'd0, 0};
    vecs[1] = '{32'h0000_0004, 3'd0, 8'h01, 0, 64'h1111,               2'b10, 1, 8'h04, 3'd0, 0};
    vecs[2] = '{32'h0000_0000, 3'd3, 8'h08, 0, 64'h2222_0000,          2'b10, 1, 8'h00, 3'd3, 0};
    vecs[3] = '{32'h0000_1000, 3'd3, 8'h08, 1, 64'h3300,               2'b00, 0, 8'h00, 3'd0, 4};
    vecs[4] = '{32'h0000_2000, 3'd2, 8'h02, 0, 64'h4400,               2'b10, 0, 8'h00, 3'd0, 3};
    vecs[5] = '{32'hFFFF_FFF8, 3'd1, 8'h02, 0, 64'h5500,               2'b00, 0, 8'h00, 3'd0, 2};
    vecs[6] = '{32'h0000_0000, 3'd0, 8'h00, 0, 64'h66,                 2'b10, 1, 8'h00, 3'd0, 0};
    vecs[7] = '{32'h0000_0100, 3'd7, 8'h80, 0, 64'h7700,               2'b00, 0, 8'h00, 3'd0, 8};
    vecs[8] = '{32'h0000_003C, 3'd1, 8'h02, 0, 64'h8888_8888_8888_8888, 2'b10, 1, 8'h3C, 3'd1, 0};

    // reset state
    #12;
    chk("rst awready", bus.awready, 1);
    chk("rst wready", bus.wready, 0);
    chk("rst bvalid", bus.bvalid, 0);
    chk("rst bresp", bus.bresp, 0);
    chk("rst strobe", bus.config_wstrobe, 0);
    chk("rst mem_valid", bus.mem_req_valid, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // single-beat config latency with AW and W presented together
    @(posedge clk); #1;
    bus.awvalid = 1'b1; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid = 1'b1; bus.wdata = 64'h2; bus.wlast = 1'b1;
    @(negedge clk);
    chk("c0 awready", bus.awready, 1);
    chk("c0 wready", bus.wready, 0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    @(negedge clk);
    chk("c1 wready", bus.wready, 1);
    chk("c1 strobe", bus.config_wstrobe, 0);
    chk("c1 awready", bus.awready, 0);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge clk);
    chk("c2 strobe", bus.config_wstrobe, 1);
    chk("c2 waddr", bus.waddr, 8'h00);
    chk("c2 wburst", bus.wburst, 3'd0);
    chk("c2 cfg_wdata", bus.cfg_wdata, 64'h2);
    @(negedge clk);
    chk("c3 strobe", bus.config_wstrobe, 0);
    chk("c3 bvalid", bus.bvalid, 0);
    @(negedge clk);
    chk("c4 bvalid", bus.bvalid, 1);
    chk("c4 bresp", bus.bresp, BRESP_OKAY);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d bvalid", i), bus.bvalid, 1);
      chk($sformatf("stall%0d bresp", i), bus.bresp, BRESP_OKAY);
      chk($sformatf("stall%0d awready", i), bus.awready, 0);
    end
    @(posedge clk); #1;
    bus.bready = 1'b1;
    @(negedge clk);
    chk("bhs bvalid", bus.bvalid, 1);
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    chk("post-b awready", bus.awready, 1);
    chk("post-b bvalid", bus.bvalid, 0);

    // transaction table
    for (int v = 0; v < 9; v++) begin
      rdy_toggle = vecs[v].toggle;
      s0 = strobes; m0 = mem_n; w0 = w_n;
      run_txn(vecs[v].addr, vecs[v].len, vecs[v].wlast_mask, vecs[v].data, resp, ok);
      rdy_toggle = 1'b0;
      chk($sformatf("v%0d handshakes", v), ok, 1);
      chk($sformatf("v%0d bresp", v), resp, vecs[v].exp_bresp);
      chk($sformatf("v%0d strobes", v), strobes - s0, vecs[v].exp_strobes);
      chk($sformatf("v%0d wbeats", v), w_n - w0, int'(vecs[v].len) + 1);
      chk($sformatf("v%0d mem beats", v), mem_n - m0, vecs[v].exp_mem);
      if (vecs[v].exp_strobes != 0) begin
        chk($sformatf("v%0d waddr", v), s_waddr, vecs[v].exp_waddr);
        chk($sformatf("v%0d wburst", v), s_wburst, vecs[v].exp_wburst);
        chk($sformatf("v%0d cfg_wdata", v), s_wdata, vecs[v].data);
      end
      for (int i = 0; i < vecs[v].exp_mem && i < mem_n - m0; i++) begin
        ea = vecs[v].addr + 32'(8 * i);
        chk($sformatf("v%0d b%0d addr", v, i), m_addr[(m0 + i) % 64], ea);
        chk($sformatf("v%0d b%0d data", v, i), m_data[(m0 + i) % 64], vecs[v].data + 64'(i));
        chk($sformatf("v%0d b%0d last", v, i), m_last[(m0 + i) % 64], i == int'(vecs[v].len));
      end
    end

    // reset in the middle of a memory burst
    s0 = strobes; b0 = bvalid_n;
    @(posedge clk); #1;
    bus.awvalid = 1'b1; bus.awaddr = 32'h3000; bus.awlen = 3'd3;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 64'hAB; bus.wlast = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid mem_valid", bus.mem_req_valid, 1);
    chk("mid mem_addr", bus.mem_req_addr, 32'h3010);
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    chk("arst awready", bus.awready, 1);
    chk("arst wready", bus.wready, 0);
    chk("arst mem_valid", bus.mem_req_valid, 0);
    chk("arst mem_addr", bus.mem_req_addr, 0);
    chk("arst mem_last", bus.mem_req_last, 0);
    chk("arst bvalid", bus.bvalid, 0);
    chk("arst bresp", bus.bresp, 0);
    chk("arst strobe", bus.config_wstrobe, 0);
    chk("arst waddr", bus.waddr, 0);
    chk("arst wburst", bus.wburst, 0);
    chk("arst cfg_wdata", bus.cfg_wdata, 0);
    bus.wvalid = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    bus.bready = 1'b1;
    repeat (6) @(negedge clk);
    bus.bready = 1'b0;
    chk("post-rst bvalid count", bvalid_n - b0, 0);
    chk("post-rst strobe count", strobes - s0, 0);
    chk("post-rst awready", bus.awready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
